acorn128_decrypt_verify: RTL and testbench
==========================================

Name: acorn128_decrypt_verify

Overview:
Bit-serial ACORN-128 authenticated decryptor, the receive-side counterpart of the encrypt top. Takes a fixed 128-bit block each of key, IV, associated data and ciphertext, plus the received tag. Produces the plaintext, the recomputed tag and a tag-match flag. One cipher step per clock through initialization, AD, decryption and finalization phases.

Parameters:
INIT_STEPS, 1792, initialization step count
AD_STEPS, 384, AD steps (128 data + 256 pad)
MSG_STEPS, 384, message steps (128 data + 256 pad)
FINAL_STEPS, 768, finalization steps; the last 128 produce the tag

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (asserted at 0)
start_in  input  1  request an operation; sampled only in IDLE or DONE
key_in  input  128  key, bit i used at init step i
iv_in  input  128  IV
associated_data_in  input  128  AD block
ciphertext_in  input  128  ciphertext block
tag_in  input  128  received tag
plaintext_out  output  128  recovered plaintext
tag_out  output  128  recomputed tag
tag_ok_out  output  1  1 when tag_out == tag_in; valid while done_out=1
busy_out  output  1  operation in progress
done_out  output  1  result valid; held until the next accepted start or reset

Behaviour:
- Reset (rst=0, async): FSM=IDLE, 293-bit state, counter, all outputs and internal input copies cleared to 0. Applies mid-operation with no partial results retained.
- FSM states: IDLE → INIT → AD → DEC → FINAL → DONE. Counter resets to 0 on each phase entry. Transition occurs on the final step of the phase.
- Accept: start_in=1 in IDLE or DONE. All 128-bit inputs are latched, the state is zeroed, done_out clears, busy_out is set and the FSM enters INIT. start_in is ignored in every other state.
- Step rules per cycle, with ks = keystream bit of the current state and m = bit fed to the update:
  - INIT step i: m = key[i] for i<128; m = iv[i-128] for i<256; m = key[0]^1 for i=256; otherwise m = key[i mod 128]. ca=1, cb=1.
  - AD step i: m = ad[i] for i<128; m = 1 for i=128; otherwise 0. cb=1. ca=1 for i<256, else 0.
  - DEC step i<128: p = ciphertext[i]^ks; plaintext bit i is registered; m = p.
  - DEC step i≥128: m = 1 at i=128, otherwise 0. cb=0. ca=1 for i<256, else 0.
  - FINAL step i: m=0, ca=1, cb=1. For i≥640, tag bit (i-640) = ks.
- Latency: 3328 steps. done_out rises on the edge 3329 cycles after the accepting edge. busy_out is high for exactly 3328 cycles.
- tag_ok_out is registered in the same cycle done_out rises. It is a full 128-bit equality.
- Start in DONE: a new operation begins the next cycle. done_out and tag_ok_out fall, and plaintext_out and tag_out clear.
- Inputs may change freely after acceptance because only the latched copies are used.

Optional Feature:
ACORN_RELEASE_GATE_EN.
- Defined: plaintext is held in an internal register. plaintext_out reads 0 unless done_out=1 and tag_ok_out=1, so unauthenticated plaintext is never exposed.
- Undefined: plaintext_out shows the plaintext register directly. Bits appear as they are decrypted during DEC, and the block is not gated by tag_ok_out.

Decomposition:
- Package acorn128_pkg:
  - phase enum (IDLE, INIT, AD, DEC, FINAL, DONE)
  - step-count constants
  - LFSR tap-position constants (state length 293, segment boundaries 61/107/154/193/230/289)
- Sub-module acorn128_step: purely combinational one-step function.
  - Inputs: state, m, ca, cb.
  - Outputs: ks, next state.
  - Contains keystream, feedback and shift logic. The top owns the FSM, counter and registers.

Test Plan:
- Loopback: encrypt key=0x000102…0F, iv=0x0F0E…00, ad=0x0, pt=0xDEADBEEF_00000000_CAFEF00D_12345678 with the existing encryptor. Feed its ciphertext and tag here → plaintext_out equals pt, tag_out equals the encryptor tag, tag_ok_out=1.
- Same vector with ciphertext bit 5 flipped → plaintext bit 5 differs, tag_ok_out=0. With the gate macro defined, plaintext_out=0.
- Same vector with tag_in bit 127 flipped → plaintext correct, tag_ok_out=0.
- Latency: count cycles from the accepting edge → busy_out high exactly 3328 cycles, done_out rises at cycle 3329. Toggle start_in during busy → no effect on result or timing.
- Reset pulse at cycle 2000 → all outputs 0 and busy_out=0 immediately. The next start reproduces the loopback result.
- Back-to-back: start_in held high in DONE → done_out drops the next cycle, and the second operation completes with the correct result for new inputs (all-zero key/iv/ad/ct against the encryptor reference tag).

Source files
------------

// File: rtl/acorn128_pkg.sv
// Shared types and constants for the bit-serial ACORN-128 datapath:
// phase encoding, step counts, state geometry and the boolean helpers.
package acorn128_pkg;

  localparam int STATE_W = 293;
  localparam int CNT_W   = 11;
  localparam int BLK_W   = 128;

  localparam int ACORN_INIT_STEPS  = 1792;
  localparam int ACORN_AD_STEPS    = 384;
  localparam int ACORN_MSG_STEPS   = 384;
  localparam int ACORN_FINAL_STEPS = 768;

  // Upper ends of the six LFSR segments that make up the 293-bit state
  localparam int SEG_B1 = 61;
  localparam int SEG_B2 = 107;
  localparam int SEG_B3 = 154;
  localparam int SEG_B4 = 193;
  localparam int SEG_B5 = 230;
  localparam int SEG_B6 = 289;

  localparam logic [CNT_W-1:0] CNT_BLK     = 11'd128;
  localparam logic [CNT_W-1:0] CNT_PAD_END = 11'd256;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_AD    = 3'd2,
    PH_DEC   = 3'd3,
    PH_FINAL = 3'd4,
    PH_DONE  = 3'd5
  } phase_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch3(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// One ACORN-128 state update: segment feedback, keystream bit, nonlinear
// feedback and a one-bit shift. Purely combinational.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic               ks,
  output logic [STATE_W-1:0] state_next
);

  logic [STATE_W-1:0] s;
  logic               f;

  // Every segment update reads only pre-update bits, so ordering is free
  always_comb begin
    s         = state;
    s[SEG_B6] = state[SEG_B6] ^ state[235] ^ state[SEG_B5];
    s[SEG_B5] = state[SEG_B5] ^ state[196] ^ state[SEG_B4];
    s[SEG_B4] = state[SEG_B4] ^ state[160] ^ state[SEG_B3];
    s[SEG_B3] = state[SEG_B3] ^ state[111] ^ state[SEG_B2];
    s[SEG_B2] = state[SEG_B2] ^ state[66]  ^ state[SEG_B1];
    s[SEG_B1] = state[SEG_B1] ^ state[23]  ^ state[0];
  end

  assign ks = s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ ch3(s[230], s[111], s[66]);
  assign f  = s[0] ^ ~s[107] ^ maj3(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);

  assign state_next = {f ^ m, s[STATE_W-1:1]};

endmodule

// File: rtl/acorn128_decrypt_verify.sv
// Bit-serial ACORN-128 decryptor with tag recomputation and compare.
// Define ACORN_RELEASE_GATE_EN to hide plaintext until the tag verifies.
module acorn128_decrypt_verify
  import acorn128_pkg::*;
#(
  parameter int INIT_STEPS  = ACORN_INIT_STEPS,
  parameter int AD_STEPS    = ACORN_AD_STEPS,
  parameter int MSG_STEPS   = ACORN_MSG_STEPS,
  parameter int FINAL_STEPS = ACORN_FINAL_STEPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic [127:0] associated_data_in,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] tag_in,
  output logic [127:0] plaintext_out,
  output logic [127:0] tag_out,
  output logic         tag_ok_out,
  output logic         busy_out,
  output logic         done_out
);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_STEPS - 1);
  localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(AD_STEPS - 1);
  localparam logic [CNT_W-1:0] MSG_LAST   = CNT_W'(MSG_STEPS - 1);
  localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(FINAL_STEPS - 1);
  localparam logic [CNT_W-1:0] TAG_FIRST  = CNT_W'(FINAL_STEPS - BLK_W);

  phase_t             phase;
  phase_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [127:0]       key_q, iv_q, ad_q, ct_q, tag_in_q;
  logic [127:0]       pt_q, tag_q;
  logic               tag_ok_q, busy_q, done_q;
  logic               m, ca, cb, ks, p_bit, last;
  logic [6:0]         idx;

  assign idx = cnt[6:0];

  acorn128_step u_step (
    .state      (state),
    .m          (m),
    .ca         (ca),
    .cb         (cb),
    .ks         (ks),
    .state_next (state_next)
  );

  // Per-phase choice of the fed bit and the two control bits
  always_comb begin
    m     = 1'b0;
    ca    = 1'b1;
    cb    = 1'b1;
    last  = 1'b0;
    nxt   = phase;
    p_bit = ct_q[idx] ^ ks;
    case (phase)
      PH_INIT: begin
        last = (cnt == INIT_LAST);
        nxt  = PH_AD;
        if (cnt < CNT_BLK)          m = key_q[idx];
        else if (cnt < CNT_PAD_END) m = iv_q[idx];
        else if (cnt == CNT_PAD_END) m = ~key_q[0];
        else                        m = key_q[idx];
      end
      PH_AD: begin
        last = (cnt == AD_LAST);
        nxt  = PH_DEC;
        m    = (cnt < CNT_BLK) ? ad_q[idx] : (cnt == CNT_BLK);
        ca   = (cnt < CNT_PAD_END);
      end
      PH_DEC: begin
        last = (cnt == MSG_LAST);
        nxt  = PH_FINAL;
        m    = (cnt < CNT_BLK) ? p_bit : (cnt == CNT_BLK);
        ca   = (cnt < CNT_PAD_END);
        cb   = 1'b0;
      end
      PH_FINAL: begin
        last = (cnt == FINAL_LAST);
        nxt  = PH_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      state    <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      ad_q     <= '0;
      ct_q     <= '0;
      tag_in_q <= '0;
      pt_q     <= '0;
      tag_q    <= '0;
      tag_ok_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE, PH_DONE: begin
          // The full tag lands on the last FINAL edge; compare it one edge later
          if (phase == PH_DONE && !done_q) begin
            done_q   <= 1'b1;
            tag_ok_q <= (tag_q == tag_in_q);
          end
          if (start_in) begin
            key_q    <= key_in;
            iv_q     <= iv_in;
            ad_q     <= associated_data_in;
            ct_q     <= ciphertext_in;
            tag_in_q <= tag_in;
            state    <= '0;
            cnt      <= '0;
            pt_q     <= '0;
            tag_q    <= '0;
            tag_ok_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            phase    <= PH_INIT;
          end
        end
        PH_INIT, PH_AD, PH_DEC, PH_FINAL: begin
          state <= state_next;
          cnt   <= last ? '0 : cnt + 1'b1;
          if (phase == PH_DEC && cnt < CNT_BLK)
            pt_q[idx] <= p_bit;
          if (phase == PH_FINAL && cnt >= TAG_FIRST)
            tag_q[7'(cnt - TAG_FIRST)] <= ks;
          if (last) begin
            phase  <= nxt;
            busy_q <= (phase != PH_FINAL);
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

`ifdef ACORN_RELEASE_GATE_EN
  assign plaintext_out = (done_q && tag_ok_q) ? pt_q : '0;
`else
  assign plaintext_out = pt_q;
`endif

  assign tag_out    = tag_q;
  assign tag_ok_out = tag_ok_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_acorn128_decrypt_verify.sv
// Bench for acorn128_decrypt_verify: behavioural ACORN-128 reference,
// vector table, result scoreboard and hand-written reset/latency sequences.
module tb_acorn128_decrypt_verify;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_in = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;
  logic [127:0] associated_data_in = '0;
  logic [127:0] ciphertext_in = '0;
  logic [127:0] tag_in = '0;
  logic [127:0] plaintext_out;
  logic [127:0] tag_out;
  logic         tag_ok_out;
  logic         busy_out;
  logic         done_out;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] ad;
    logic [127:0] ct;
    logic [127:0] tg;
    logic [127:0] pt;
    logic [127:0] tag;
    logic         ok;
  } vec_t;

  vec_t         vecs[4];
  vec_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [292:0] rs;

  always #5 clk = ~clk;

  acorn128_decrypt_verify dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .key_in             (key_in),
    .iv_in              (iv_in),
    .associated_data_in (associated_data_in),
    .ciphertext_in      (ciphertext_in),
    .tag_in             (tag_in),
    .plaintext_out      (plaintext_out),
    .tag_out            (tag_out),
    .tag_ok_out         (tag_ok_out),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic rmaj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic rch(input logic x, input logic y, input logic z);
    return x ? y : z;
  endfunction

  // In-place reference step; xk=1 makes the fed bit din^ks (decrypt direction)
  task automatic ref_step(input logic din, input logic xk, input logic ca, input logic cb,
                          output logic ks);
    logic fb, m;
    rs[289] = rs[289] ^ rs[235] ^ rs[230];
    rs[230] = rs[230] ^ rs[196] ^ rs[193];
    rs[193] = rs[193] ^ rs[160] ^ rs[154];
    rs[154] = rs[154] ^ rs[111] ^ rs[107];
    rs[107] = rs[107] ^ rs[66]  ^ rs[61];
    rs[61]  = rs[61]  ^ rs[23]  ^ rs[0];
    ks = rs[12] ^ rs[154] ^ rmaj(rs[235], rs[61], rs[193]) ^ rch(rs[230], rs[111], rs[66]);
    m  = din ^ (xk & ks);
    fb = rs[0] ^ ~rs[107] ^ rmaj(rs[244], rs[23], rs[160]) ^ (ca & rs[196]) ^ (cb & ks);
    rs = {fb ^ m, rs[292:1]};
  endtask

  task automatic ref_run(input logic [127:0] key, input logic [127:0] iv, input logic [127:0] ad,
                         input logic [127:0] din, input logic dec,
                         output logic [127:0] dout, output logic [127:0] tag);
    logic ks, m;
    rs = '0; dout = '0; tag = '0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       m = key[7'(i)];
      else if (i < 256)  m = iv[7'(i - 128)];
      else if (i == 256) m = ~key[0];
      else               m = key[7'(i)];
      ref_step(m, 1'b0, 1'b1, 1'b1, ks);
    end
    for (int i = 0; i < 384; i++) begin
      m = (i < 128) ? ad[7'(i)] : (i == 128);
      ref_step(m, 1'b0, (i < 256), 1'b1, ks);
    end
    for (int i = 0; i < 384; i++) begin
      m = (i < 128) ? din[7'(i)] : (i == 128);
      ref_step(m, dec && (i < 128), (i < 256), 1'b0, ks);
      if (i < 128) dout[7'(i)] = din[7'(i)] ^ ks;
    end
    for (int i = 0; i < 768; i++) begin
      ref_step(1'b0, 1'b0, 1'b1, 1'b1, ks);
      if (i >= 640) tag[7'(i - 640)] = ks;
    end
  endtask

  function automatic vec_t mk(input logic [127:0] key, input logic [127:0] iv, input logic [127:0] ad,
                              input logic [127:0] ct, input logic [127:0] tg, input logic [127:0] pt,
                              input logic [127:0] tag, input logic ok);
    vec_t v;
    v.key = key; v.iv = iv; v.ad = ad; v.ct = ct; v.tg = tg; v.pt = pt; v.tag = tag; v.ok = ok;
    return v;
  endfunction

  task automatic check_all_zero(input string tag_name);
    check({tag_name, "_plaintext"}, plaintext_out, '0);
    check({tag_name, "_tag"}, tag_out, '0);
    check({tag_name, "_tag_ok"}, {127'd0, tag_ok_out}, '0);
    check({tag_name, "_busy"}, {127'd0, busy_out}, '0);
    check({tag_name, "_done"}, {127'd0, done_out}, '0);
  endtask

  // Called at a negedge; returns 1ns after the accepting edge
  task automatic start_op(input int k, input logic b2b);
    key_in             = vecs[k].key;
    iv_in              = vecs[k].iv;
    associated_data_in = vecs[k].ad;
    ciphertext_in      = vecs[k].ct;
    tag_in             = vecs[k].tg;
    start_in           = 1'b1;
    sb_q.push_back(vecs[k]);
    @(posedge clk);
    #1;
    start_in = 1'b0;
    if (b2b) begin
      check("b2b_done_low", {127'd0, done_out}, '0);
      check("b2b_tag_ok_low", {127'd0, tag_ok_out}, '0);
      check("b2b_plaintext_clear", plaintext_out, '0);
      check("b2b_tag_clear", tag_out, '0);
      check("b2b_busy", {127'd0, busy_out}, 128'd1);
    end
    key_in             = {$urandom, $urandom, $urandom, $urandom};
    iv_in              = {$urandom, $urandom, $urandom, $urandom};
    associated_data_in = {$urandom, $urandom, $urandom, $urandom};
    ciphertext_in      = {$urandom, $urandom, $urandom, $urandom};
    tag_in             = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input logic timing);
    int           cyc = 0;
    int           busy_cnt = 0;
    logic         got = 1'b0;
    vec_t         e;
    logic [127:0] want_pt;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start_in = (timing && cyc < 3300) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy_out) busy_cnt++;
      if (done_out) begin
        got = 1'b1;
        break;
      end
    end
    start_in = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_out within %0d cycles", cyc);
      return;
    end
    if (timing) begin
      check("busy_cycles", 128'(busy_cnt), 128'd3328);
      check("done_edge", 128'(cyc - 1), 128'd3329);
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got done_out with no expected entry");
      return;
    end
    e = sb_q.pop_front();
    want_pt = e.pt;
`ifdef ACORN_RELEASE_GATE_EN
    if (!e.ok) want_pt = '0;
`endif
    check("plaintext", plaintext_out, want_pt);
    check("tag", tag_out, e.tag);
    check("tag_ok", {127'd0, tag_ok_out}, {127'd0, e.ok});
  endtask

  initial begin
    logic [127:0] k0, v0, p0, c0, t0, cf, pf, tf, pz, tz;
    vec_t         dropped;

    k0 = 128'h000102030405060708090A0B0C0D0E0F;
    v0 = 128'h0F0E0D0C0B0A09080706050403020100;
    p0 = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    ref_run(k0, v0, '0, p0, 1'b0, c0, t0);
    cf = c0 ^ (128'd1 << 5);
    ref_run(k0, v0, '0, cf, 1'b1, pf, tf);
    ref_run('0, '0, '0, '0, 1'b1, pz, tz);
    vecs[0] = mk(k0, v0, '0, c0, t0, p0, t0, 1'b1);
    vecs[1] = mk(k0, v0, '0, cf, t0, pf, tf, 1'b0);
    vecs[2] = mk(k0, v0, '0, c0, t0 ^ (128'd1 << 127), p0, t0, 1'b0);
    vecs[3] = mk('0, '0, '0, '0, tz, pz, tz, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    start_op(0, 1'b0);
    wait_done(1'b1);
    for (int k = 1; k < 3; k++) begin
      start_op(k, 1'b0);
      wait_done(1'b0);
    end

    start_op(0, 1'b0);
    repeat (2000) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    dropped = sb_q.pop_front();
    @(negedge clk);
    rst = 1'b1;
    start_op(0, 1'b0);
    wait_done(1'b0);

    start_op(3, 1'b1);
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
